// File: rtl/regfile_param.sv
// Parametrised register file: two async read ports, one write port, registered rd readback,
// immediate extender and a post-reset scrub FSM. Optional write-to-read forwarding under REGFILE_BYPASS_EN.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int IMM_W    = 16,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write,
    input  logic              reg_dst,
    input  logic [1:0]        ext_op,
    input  logic [ADDR_W-1:0] rs_add,
    input  logic [ADDR_W-1:0] rt_add,
    input  logic [ADDR_W-1:0] rd_add,
    input  logic [DATA_W-1:0] write_data,
    input  logic [IMM_W-1:0]  imm_val,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] ext_imm,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DATA_W-1:0] regs_q [DEPTH];

    logic [ADDR_W-1:0] dest;
    logic              zero_dest;
    logic              wr_en;
    logic [DATA_W-1:0] rs_arr;
    logic [DATA_W-1:0] rt_arr;

    function automatic logic [DATA_W-1:0] extend_imm(input logic [IMM_W-1:0] imm,
                                                     input logic [1:0]       op);
        logic signed [IMM_W-1:0] imm_s;
        logic [DATA_W-1:0]       zext;
        imm_s = $signed(imm);
        zext  = DATA_W'(imm);
        case (op)
            2'b01:   return DATA_W'(imm_s);
            2'b10:   return zext << (DATA_W - IMM_W);
            default: return zext;
        endcase
    endfunction

    // Scrub FSM: next state and busy
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        busy      = (state_q == CLEAR);
        case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LAST_IDX) begin
                    clr_idx_d = '0;
                    state_d   = RUN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Write decode: writes are only live in RUN, outside reset, and never to a hardwired zero register
    assign dest      = reg_dst ? rd_add : rt_add;
    assign zero_dest = (ZERO_REG != 0) && (dest == '0);
    assign wr_en     = (state_q == RUN) && !rst && reg_write && !zero_dest;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                regs_q[clr_idx_q] <= '0;
            end else if (wr_en) begin
                regs_q[dest] <= write_data;
            end
        end
    end

    // rd readback shows the post-edge contents, so a same-edge write to rd_add wins
    always_comb begin
        rd_data_d = rd_data_q;
        if (state_q == RUN) begin
            if (wr_en && (dest == rd_add)) begin
                rd_data_d = write_data;
            end else if ((ZERO_REG != 0) && (rd_add == '0)) begin
                rd_data_d = '0;
            end else begin
                rd_data_d = regs_q[rd_add];
            end
        end
    end

    assign rs_arr = ((ZERO_REG != 0) && (rs_add == '0)) ? '0 : regs_q[rs_add];
    assign rt_arr = ((ZERO_REG != 0) && (rt_add == '0)) ? '0 : regs_q[rt_add];

`ifdef REGFILE_BYPASS_EN
    assign rs_data = (wr_en && (rs_add == dest)) ? write_data : rs_arr;
    assign rt_data = (wr_en && (rt_add == dest)) ? write_data : rt_arr;
`else
    assign rs_data = rs_arr;
    assign rt_data = rt_arr;
`endif

    assign rd_data = rd_data_q;
    assign ext_imm = extend_imm(imm_val, ext_op);

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: scrub timing, table-driven read/write/extend vectors,
// zero-register variants, bypass behaviour and reset during scrub.
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        reg_write;
    logic        reg_dst;
    logic [1:0]  ext_op;
    logic [4:0]  rs_add, rt_add, rd_add;
    logic [31:0] write_data;
    logic [15:0] imm_val;
    logic [31:0] rs0, rt0, rd0, ext0;
    logic [31:0] rs1, rt1, rd1, ext1;
    logic        busy0, busy1;

    int checks = 0;
    int errors = 0;

    regfile_param dut0 (
        .clk(clk), .rst(rst), .reg_write(reg_write), .reg_dst(reg_dst), .ext_op(ext_op),
        .rs_add(rs_add), .rt_add(rt_add), .rd_add(rd_add), .write_data(write_data),
        .imm_val(imm_val), .rs_data(rs0), .rt_data(rt0), .rd_data(rd0), .ext_imm(ext0),
        .busy(busy0)
    );

    regfile_param #(.ZERO_REG(0)) dut1 (
        .clk(clk), .rst(rst), .reg_write(reg_write), .reg_dst(reg_dst), .ext_op(ext_op),
        .rs_add(rs_add), .rt_add(rt_add), .rd_add(rd_add), .write_data(write_data),
        .imm_val(imm_val), .rs_data(rs1), .rt_data(rt1), .rd_data(rd1), .ext_imm(ext1),
        .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        dst;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [15:0] imm;
        logic [1:0]  op;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic [31:0] e_ext;
        logic [31:0] e_rd;
        logic [31:0] e_rs1;
        logic [31:0] e_rd1;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic count_scrub(input string name);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (busy0 && n < 100);
        chk(name, 32'(n), 32'd32);
        chk({name, " busy1"}, 32'(busy1), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 0; i < 32; i++) begin
            rs_add = 5'(i);
            rt_add = 5'(31 - i);
            #1;
            chk($sformatf("%s r%0d z1", name, i), rs0, 32'h0);
            chk($sformatf("%s r%0d z0", name, i), rs1, 32'h0);
        end
    endtask

    initial begin
        vt[0] = '{1'b1, 1'b1, 5'd6,  5'd0, 5'd5,  32'hDEADBEEF, 16'h8001, 2'b00,
                  32'h0, 32'h0, 32'h00008001, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
        vt[1] = '{1'b0, 1'b0, 5'd5,  5'd7, 5'd5,  32'h0, 16'h8001, 2'b01,
                  32'hDEADBEEF, 32'h0, 32'hFFFF8001, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vt[2] = '{1'b1, 1'b0, 5'd5,  5'd7, 5'd5,  32'h00001234, 16'h8001, 2'b10,
                  32'hDEADBEEF, (BYP ? 32'h00001234 : 32'h0), 32'h80010000, 32'hDEADBEEF,
                  32'hDEADBEEF, 32'hDEADBEEF};
        vt[3] = '{1'b0, 1'b0, 5'd7,  5'd5, 5'd7,  32'h0, 16'h8001, 2'b11,
                  32'h00001234, 32'hDEADBEEF, 32'h00008001, 32'h00001234, 32'h00001234, 32'h00001234};
        vt[4] = '{1'b1, 1'b1, 5'd0,  5'd5, 5'd0,  32'hFFFFFFFF, 16'h7FFF, 2'b00,
                  32'h0, 32'hDEADBEEF, 32'h00007FFF, 32'h0, (BYP ? 32'hFFFFFFFF : 32'h0), 32'hFFFFFFFF};
        vt[5] = '{1'b0, 1'b0, 5'd0,  5'd0, 5'd0,  32'h0, 16'h7FFF, 2'b01,
                  32'h0, 32'h0, 32'h00007FFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vt[6] = '{1'b1, 1'b1, 5'd30, 5'd1, 5'd31, 32'hCAFEF00D, 16'hFFFF, 2'b10,
                  32'h0, 32'h0, 32'hFFFF0000, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D};
        vt[7] = '{1'b0, 1'b0, 5'd31, 5'd5, 5'd7,  32'h0, 16'hFFFF, 2'b01,
                  32'hCAFEF00D, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h00001234, 32'hCAFEF00D, 32'h00001234};

        rst = 1'b1; reg_write = 1'b0; reg_dst = 1'b0; ext_op = 2'b00;
        rs_add = '0; rt_add = '0; rd_add = '0; write_data = '0; imm_val = '0;
        cyc();
        cyc();
        chk("reset busy0", 32'(busy0), 32'd1);
        chk("reset rd0", rd0, 32'h0);
        chk("reset busy1", 32'(busy1), 32'd1);
        chk("reset rd1", rd1, 32'h0);
        rst = 1'b0;
        count_scrub("scrub0 len");

        // Preload some non-zero contents so the next scrub has work to do
        reg_write = 1'b1; reg_dst = 1'b1;
        rd_add = 5'd0;  write_data = 32'h11111111; cyc();
        rd_add = 5'd9;  write_data = 32'h00000099; cyc();
        rd_add = 5'd31; write_data = 32'h00000031; cyc();
        reg_write = 1'b0;
        rs_add = 5'd9; #1;
        chk("preload r9", rs0, 32'h00000099);
        rs_add = 5'd0; #1;
        chk("preload r0 z0", rs1, 32'h11111111);

        // Reset pulse with a write held asserted through the whole scrub
        reg_write = 1'b1; reg_dst = 1'b1; rd_add = 5'd2; write_data = 32'h00000055;
        rst = 1'b1;
        cyc();
        chk("rst pulse busy", 32'(busy0), 32'd1);
        rst = 1'b0;
        count_scrub("scrub1 len");
        reg_write = 1'b0;
        check_all_zero("scrub1");

        for (int i = 0; i < 8; i++) begin
            reg_write = vt[i].we; reg_dst = vt[i].dst;
            rs_add = vt[i].rs; rt_add = vt[i].rt; rd_add = vt[i].rd;
            write_data = vt[i].wd; imm_val = vt[i].imm; ext_op = vt[i].op;
            #1;
            chk($sformatf("v%0d rs", i), rs0, vt[i].e_rs);
            chk($sformatf("v%0d rt", i), rt0, vt[i].e_rt);
            chk($sformatf("v%0d ext", i), ext0, vt[i].e_ext);
            chk($sformatf("v%0d rs z0", i), rs1, vt[i].e_rs1);
            cyc();
            chk($sformatf("v%0d rd", i), rd0, vt[i].e_rd);
            chk($sformatf("v%0d rd z0", i), rd1, vt[i].e_rd1);
        end

        // Same-cycle read of the register being written
        reg_write = 1'b1; reg_dst = 1'b1; rd_add = 5'd3; write_data = 32'hA5A5A5A5; rs_add = 5'd3;
        #1;
        chk("bypass same", rs0, BYP ? 32'hA5A5A5A5 : 32'h0);
        cyc();
        reg_write = 1'b0;
        #1;
        chk("bypass next", rs0, 32'hA5A5A5A5);

        // Reset landing at scrub index 10 restarts the full scrub
        reg_write = 1'b1; rd_add = 5'd20; write_data = 32'h00000020;
        cyc();
        reg_write = 1'b0;
        rst = 1'b1; cyc(); rst = 1'b0;
        repeat (10) cyc();
        chk("mid busy", 32'(busy0), 32'd1);
        rst = 1'b1; cyc(); rst = 1'b0;
        count_scrub("scrub mid len");
        check_all_zero("scrub mid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
